// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and width codes for the memory arbiter
// Purpose: arbiter FSM state type, memory access width codes and width normalisation.
// Ports: none (package).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Same encoding as funct3[1:0] so the decoder's mem_width feeds straight through.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // The unused code 11 is folded onto a word access.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'b11) ? MEM_WORD : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// rtl/mem_arbiter_starve_counter.sv - saturating count of data grants taken while fetch waits
// Purpose: tracks how long fetch has been passed over; limit_o forces the next grant to fetch.
// Ports: clk_i/rst_i clock and async active-high reset; inc_i count one data grant;
//        clr_i clear (wins over inc_i); limit_o count has reached LIMIT.
module starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [3:0] LIMIT_C = LIMIT[3:0];

  logic [3:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != LIMIT_C)) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign limit_o = (count_q == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Purpose: grants one transaction at a time to the data port (priority) or fetch port,
//          with a starvation guard for fetch and flush-driven dropping of fetch responses.
// Ports: clk_i/rst_i clock and async active-high reset;
//        if_* fetch request/address in, instruction data and ack pulse out; flush_i cancel fetch;
//        dm_* data request/we/width/address/wdata in, load data and ack pulse out;
//        mem_* request/we/width/address/wdata out to memory, rdata/ack back; busy_o not idle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [1:0]        dm_width_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_width_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  arb_state_e        state_q, state_d;
  logic              fetch_ok, grant_d, grant_i, starved;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, fetch_q, drop_q;
  logic [1:0]        width_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (grant_d && if_req_i),
    .clr_i   (grant_i || ((state_q == IDLE) && !if_req_i)),
    .limit_o (starved)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    fetch_ok = if_req_i && !flush_i;
    case (state_q)
      IDLE: begin
        // A flushed fetch cannot claim its starvation priority, so data still goes.
        if (dm_req_i && !(fetch_ok && starved)) begin
          grant_d = 1'b1;
          state_d = GNT_D;
        end else if (fetch_ok) begin
          grant_i = 1'b1;
          state_d = GNT_I;
        end
      end
      GNT_I, GNT_D: if (mem_ack_i) state_d = RESP;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      width_q <= MEM_BYTE;
      wdata_q <= '0;
      rdata_q <= '0;
      fetch_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q  <= dm_addr_i;
        we_q    <= dm_we_i;
        width_q <= norm_width(dm_width_i);
        wdata_q <= dm_wdata_i;
        fetch_q <= 1'b0;
      end else if (grant_i) begin
        addr_q  <= if_addr_i;
        we_q    <= 1'b0;
        width_q <= MEM_WORD;
        wdata_q <= '0;
        fetch_q <= 1'b1;
      end
      if (mem_req_o && mem_ack_i) rdata_q <= mem_rdata_i;
      // The memory access cannot be aborted, so a flushed fetch runs to completion
      // and only its ack is swallowed.
      if ((state_q == GNT_I) && flush_i) drop_q <= 1'b1;
      else if (state_q == RESP)          drop_q <= 1'b0;
    end
  end

  assign mem_req_o   = (state_q == GNT_I) || (state_q == GNT_D);
  assign mem_we_o    = we_q;
  assign mem_width_o = width_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign if_ack_o    = (state_q == RESP) && fetch_q && !drop_q;
  assign if_rdata_o  = if_ack_o ? rdata_q : '0;
  assign dm_ack_o    = (state_q == RESP) && !fetch_q;
  assign dm_rdata_o  = (dm_ack_o && !we_q) ? rdata_q : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (read-only) and the MEM-stage data access (load/store).
- Sits between the pipeline front/back ends and the memory model.
- Sequences one transaction at a time and exposes per-requester acks that the pipeline hazard logic turns into stalls.
- Data has priority; a starvation guard guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (range 1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request, held until if_ack_o or flush_i
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1
- if_ack_o  out  1  one-cycle fetch completion pulse
- flush_i  in  1  pipeline flush; cancels current/pending fetch
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 store, 0 load
- dm_width_i  in  2  00 byte, 01 half, 10 word (funct3[1:0] encoding)
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, valid while dm_ack_o=1
- dm_ack_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  write enable
- mem_width_o  out  2  access width
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, may arrive in the same cycle mem_req_o rises
- busy_o  out  1  state != IDLE

Behaviour:
- **Reset.** Async reset forces state IDLE, all *_o = 0, starve count 0, drop flag 0. A reset mid-transaction drops mem_req_o immediately; the memory abandons the access.
- **States.**
  - IDLE: arbitrate.
  - GNT_D / GNT_I: mem_req_o=1, payload from registers latched at grant.
  - RESP: one-cycle ack pulse.
  - RESP always returns to IDLE.
- **Arbitration in IDLE** (registered, grant takes effect next cycle):
  - dm_req_i wins unless if_req_i=1 and starve count == STARVE_LIMIT.
  - Fetch wins otherwise when if_req_i=1 and flush_i=0.
  - No request: stay IDLE.
- **Starve count.**
  - Increments on each data grant while if_req_i=1.
  - Clears on any fetch grant or when if_req_i=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- **Grant latching.** Latch addr/we/width/wdata at the grant edge. Fetch grant: we=0, width=10. Requester payload changes after the grant are ignored.
- **GNT_x.**
  - mem_req_o stays 1 until a cycle with mem_ack_i=1.
  - On that edge: capture mem_rdata_i into the response register, drop mem_req_o, go to RESP.
- **RESP.**
  - The matching ack_o = 1 for exactly one cycle; rdata_o holds the captured value.
  - Store ack: dm_rdata_o = 0.
  - The requester drops or replaces its req in the cycle after the ack. The IDLE gap guarantees the old request is never re-granted.
- **Latency.**
  - Zero-wait memory: request seen in IDLE at cycle 0 -> mem_req_o at 1 -> ack_o at 2. Back-to-back throughput is one access per 3 cycles.
  - N wait states add N cycles.
- **Flush.**
  - flush_i in IDLE blocks a fetch grant that cycle (data is still granted).
  - flush_i in GNT_I sets the drop flag. The memory transaction completes normally, then RESP suppresses if_ack_o (if_rdata_o = 0). The drop flag clears on leaving RESP.
  - flush_i never affects data transactions.
- **Simultaneous events.**
  - dm_req_i and if_req_i both high: data wins unless starved.
  - flush_i and mem_ack_i in the same GNT_I cycle: response dropped.
- **Width codes.** Passed through unchanged. Alignment and sub-word placement are the memory's responsibility. dm_width_i=11 is treated as word.

Decomposition:
- Shared package entries:
  - State encoding: IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, RESP=2'd3.
  - Width constants: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10. These live next to the existing opcode defines so the decoder's mem_width and this block agree.
- One natural sub-module: starve_counter (saturating counter with inc/clr/limit-reached output, parameterised by STARVE_LIMIT).

Test Plan:
- **Single fetch, zero-wait.** if_req_i=1, if_addr_i=0x100, mem_ack_i tied 1, mem_rdata_i=0x00500093 -> mem_req_o high cycle 1 only; if_ack_o at cycle 2 with if_rdata_o=0x00500093; dm_ack_o never pulses.
- **Store with wait states.** dm_req_i=1, dm_we_i=1, dm_width_i=00, dm_addr_i=0x203, dm_wdata_i=0xAB; memory acks after 3 cycles -> mem_req_o held 3 cycles with stable mem_addr_o=0x203, mem_width_o=00; dm_ack_o 1 cycle later; dm_rdata_o=0.
- **Contention and starvation, STARVE_LIMIT=4.** if_req_i and dm_req_i held high, each with new requests after every ack -> grant order D,D,D,D,I,D,D,D,D,I; the fetch starves at most 4 grants.
- **Flush during fetch.** flush_i pulsed in GNT_I -> the memory transaction completes, if_ack_o stays 0, and the next IDLE accepts the new if_addr_i=0x400 fetch.
- **Async reset mid-GNT_D.** rst_i asserted between clock edges -> mem_req_o, busy_o and all acks drop before the next edge; after release, the first grant follows normal IDLE rules with starve count 0.
- **Payload change after grant.** dm_addr_i changed from 0x10 to 0x20 during GNT_D -> mem_addr_o stays 0x10 until mem_ack_i.
